// File: rtl/mul_pkg.sv
// Shared types and configuration helpers for the iterative integer multiplier.
package mul_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    localparam int XLEN_DEFAULT = 64;
    localparam int BPC_DEFAULT  = 8;
    localparam int ITER         = XLEN_DEFAULT / BPC_DEFAULT;

    function automatic bit mul_cfg_ok(input int xlen, input int bpc);
        bit xlen_ok;
        bit bpc_ok;
        xlen_ok = (xlen == 32'sd32) || (xlen == 32'sd64);
        bpc_ok  = (bpc == 32'sd1) || (bpc == 32'sd2) || (bpc == 32'sd4) ||
                  (bpc == 32'sd8) || (bpc == 32'sd16);
        return xlen_ok && bpc_ok && ((xlen % bpc) == 32'sd0);
    endfunction

endpackage

// File: rtl/cseladd.sv
// Carry-select adder: low half ripples, high half is precomputed for both
// carry-in values and selected by the low-half carry.
module cseladd #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0]   lo_s;
    logic [HI-1:0] hi0_s;
    logic [HI-1:0] hi1_s;

    assign lo_s  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
    assign hi0_s = a[W-1:LO] + b[W-1:LO];
    assign hi1_s = a[W-1:LO] + b[W-1:LO] + HI'(1'b1);
    assign sum   = {(lo_s[LO] ? hi1_s : hi0_s), lo_s[LO-1:0]};

endmodule

// File: rtl/mul_pp_step.sv
// One radix-2^BPC partial-product step: acc_nx = acc + mcand * digit.
module mul_pp_step #(
    parameter int XLEN = 64,
    parameter int BPC  = 8
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [BPC-1:0]    digit,
    output logic [2*XLEN-1:0] acc_nx
);

    logic [2*XLEN-1:0] digit_ext_s;
    logic [2*XLEN-1:0] pp_s;

    assign digit_ext_s = {{(2*XLEN-BPC){1'b0}}, digit};
    assign pp_s        = mcand * digit_ext_s;

    cseladd #(.W(2*XLEN)) u_add (
        .a   (acc),
        .b   (pp_s),
        .sum (acc_nx)
    );

endmodule

// File: rtl/int_mul_iter.sv
// Iterative M-extension multiplier retiring BPC multiplier bits per cycle.
// Optional INT_MUL_EARLY_OUT_EN: leave RUN once the remaining multiplier is zero.
module int_mul_iter
    import mul_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BPC  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int NITER = XLEN / BPC;
    localparam int CW    = $clog2(NITER + 1);
    localparam int AW    = 2 * XLEN;

    generate
        if (!mul_cfg_ok(XLEN, BPC)) begin : g_cfg_err
            $error("int_mul_iter: XLEN must be 32/64 and BPC one of 1,2,4,8,16 dividing XLEN");
        end
    endgenerate

    mul_state_e        state_r, state_s;
    mul_op_e           op_r, op_s, op_dec_s;
    logic              neg_r, neg_s;
    logic [AW-1:0]     acc_r, acc_s, acc_step_s, acc_fix_s;
    logic [AW-1:0]     mcand_r, mcand_s;
    logic [XLEN-1:0]   mplier_r, mplier_s, mplier_shr_s;
    logic [XLEN-1:0]   result_r, result_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              busy_r, valid_r;
    logic [XLEN-1:0]   a_s, b_s, mag_a_s, mag_b_s, sext_res_s;
    logic              sign_a_s, sign_b_s, last_s;
    logic signed [31:0] op1_lo_s, op2_lo_s, acc_lo_s;

    // Decode the raw opcode; unused encodings behave as MUL.
    always_comb begin
        case (op)
            3'd0:    op_dec_s = OP_MUL;
            3'd1:    op_dec_s = OP_MULH;
            3'd2:    op_dec_s = OP_MULHSU;
            3'd3:    op_dec_s = OP_MULHU;
            3'd4:    op_dec_s = OP_MULW;
            default: op_dec_s = OP_MUL;
        endcase
    end

    assign op1_lo_s = op1[31:0];
    assign op2_lo_s = op2[31:0];

    // Operand selection and sign-magnitude conversion at start.
    always_comb begin
        if (op_dec_s == OP_MULW) begin
            a_s = XLEN'(op1_lo_s);
            b_s = XLEN'(op2_lo_s);
        end else begin
            a_s = op1;
            b_s = op2;
        end
        sign_a_s = a_s[XLEN-1] & (op_dec_s inside {OP_MULH, OP_MULHSU, OP_MULW});
        sign_b_s = b_s[XLEN-1] & (op_dec_s inside {OP_MULH, OP_MULW});
        mag_a_s  = sign_a_s ? (~a_s + XLEN'(1'b1)) : a_s;
        mag_b_s  = sign_b_s ? (~b_s + XLEN'(1'b1)) : b_s;
    end

    mul_pp_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .acc    (acc_r),
        .mcand  (mcand_r),
        .digit  (mplier_r[BPC-1:0]),
        .acc_nx (acc_step_s)
    );

    assign mplier_shr_s = mplier_r >> BPC;
    assign acc_fix_s    = neg_r ? (~acc_r + AW'(1'b1)) : acc_r;
    assign acc_lo_s     = acc_fix_s[31:0];
    assign sext_res_s   = XLEN'(acc_lo_s);

    // RUN exit condition for the current step.
    always_comb begin
`ifdef INT_MUL_EARLY_OUT_EN
        last_s = (cnt_r == CW'(1'b1)) || (mplier_shr_s == {XLEN{1'b0}});
`else
        last_s = (cnt_r == CW'(1'b1));
`endif
    end

    // Next-state and datapath update; flush overrides everything, start included.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        neg_s    = neg_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        op_s     = op_dec_s;
                        neg_s    = sign_a_s ^ sign_b_s;
                        acc_s    = {AW{1'b0}};
                        mcand_s  = {{XLEN{1'b0}}, mag_a_s};
                        mplier_s = mag_b_s;
                        cnt_s    = CW'(NITER);
                        state_s  = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    acc_s    = acc_step_s;
                    mcand_s  = mcand_r << BPC;
                    mplier_s = mplier_shr_s;
                    cnt_s    = cnt_r - CW'(1'b1);
                    if (last_s) begin
                        state_s = FIX;
                    end else begin
                        state_s = RUN;
                    end
                end
                FIX: begin
                    acc_s = acc_fix_s;
                    case (op_r)
                        OP_MULH, OP_MULHSU, OP_MULHU: result_s = acc_fix_s[AW-1:XLEN];
                        OP_MULW:                      result_s = sext_res_s;
                        default:                      result_s = acc_fix_s[XLEN-1:0];
                    endcase
                    state_s = DONE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            op_r     <= OP_MUL;
            neg_r    <= 1'b0;
            acc_r    <= {AW{1'b0}};
            mcand_r  <= {AW{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            neg_r    <= neg_s;
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            cnt_r    <= cnt_s;
            result_r <= result_s;
            busy_r   <= (state_s == RUN) || (state_s == FIX);
            valid_r  <= (state_s == DONE);
        end
    end

    assign busy   = busy_r;
    assign valid  = valid_r;
    assign result = result_r;

endmodule

// File: tb/tb_int_mul_iter.sv
// Directed, table-driven bench for int_mul_iter (XLEN=64, BPC=8).
module tb_int_mul_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    int_mul_iter #(.XLEN(64), .BPC(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat_eo;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int exp_lat(input int lat_eo);
`ifdef INT_MUL_EARLY_OUT_EN
        return lat_eo;
`else
        return 10;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_vec(input int idx);
        bit busy_ok;
        op    = vecs[idx].op;
        op1   = vecs[idx].a;
        op2   = vecs[idx].b;
        start = 1'b1;
        cyc   = 0;
        step();
        start   = 1'b0;
        busy_ok = 1'b1;
        while (!valid && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
        end
        check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(exp_lat(vecs[idx].lat_eo)));
        check($sformatf("v%0d_busy_until_valid", idx), 64'(busy_ok), 64'd1);
        check($sformatf("v%0d_result", idx), result, vecs[idx].res);
        check($sformatf("v%0d_busy_at_valid", idx), 64'(busy), 64'd0);
        step();
        check($sformatf("v%0d_valid_one_cycle", idx), 64'(valid), 64'd0);
    endtask

    initial begin
        int pulses;
        int p1;
        int p2;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] prev;

        vecs[0]  = '{3'd0, 64'd3, 64'd5, 64'd15, 3};
        vecs[1]  = '{3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 10};
        vecs[2]  = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3};
        vecs[3]  = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 10};
        vecs[4]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10};
        vecs[5]  = '{3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3};
        vecs[6]  = '{3'd4, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3};
        vecs[7]  = '{3'd0, 64'h1234, 64'h10, 64'h12340, 3};
        vecs[8]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 3};
        vecs[9]  = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3};
        vecs[10] = '{3'd4, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 3};
        vecs[11] = '{3'd7, 64'd6, 64'd7, 64'd42, 3};
        vecs[12] = '{3'd3, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 3};
        vecs[13] = '{3'd0, 64'd5, 64'h100, 64'h500, 4};
        vecs[14] = '{3'd4, 64'd1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 6};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        op1   = 64'd0;
        op2   = 64'd0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_result", result, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end

        // Start while busy must be ignored; exactly one pulse.
        op = 3'd3; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0; pulses = 0; p1 = 0; r1 = 64'd0;
        while (cyc < 25) begin
            if (valid) begin
                pulses++;
                if (p1 == 0) begin p1 = cyc; r1 = result; end
            end
            if (cyc == 4) begin
                start = 1'b1; op = 3'd0; op1 = 64'd3; op2 = 64'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        check("ignore_start_pulses", 64'(pulses), 64'd1);
        check("ignore_start_cycle", 64'(p1), 64'd10);
        check("ignore_start_result", r1, 64'hFFFF_FFFF_FFFF_FFFE);

        // Back-to-back: second start in the DONE cycle.
        op = 3'd3; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0; pulses = 0; p1 = 0; p2 = 0; r1 = 64'd0; r2 = 64'd0;
        while (cyc < 30) begin
            start = 1'b0;
            if (valid) begin
                pulses++;
                if (p1 == 0) begin
                    p1 = cyc; r1 = result;
                    start = 1'b1; op = 3'd1;
                    op1 = 64'h8000_0000_0000_0000; op2 = 64'h8000_0000_0000_0000;
                end else begin
                    p2 = cyc; r2 = result;
                end
            end
            step();
        end
        start = 1'b0;
        check("b2b_pulses", 64'(pulses), 64'd2);
        check("b2b_first_cycle", 64'(p1), 64'd10);
        check("b2b_second_cycle", 64'(p2), 64'd20);
        check("b2b_first_result", r1, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b2b_second_result", r2, 64'h4000_0000_0000_0000);
        prev = 64'h4000_0000_0000_0000;

        // Flush mid-operation.
        op = 3'd3; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 5) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid) pulses++;
            step();
        end
        check("flush_no_valid", 64'(pulses), 64'd0);
        check("flush_result_held", result, prev);

        // Flush wins over start in the same cycle.
        op = 3'd0; op1 = 64'd3; op2 = 64'd5;
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (valid) pulses++;
            step();
        end
        check("flush_start_no_valid", 64'(pulses), 64'd0);
        check("flush_start_result", result, prev);

        // Asynchronous reset mid-RUN.
        op = 3'd3; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 4) step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (valid) pulses++;
        end
        check("rst_no_valid", 64'(pulses), 64'd0);
        check("rst_result_after", result, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_mul_iter.md
Name: int_mul_iter

Overview:
Parametrised iterative integer multiplier for the stage-3 functional-unit cluster; successor to the fixed 64-bit multiplier.
- Implements the full M-extension multiply set: MUL, MULH, MULHSU, MULHU, MULW.
- Retires BPC multiplier bits per cycle, with configurable XLEN.
- start/busy/valid handshake plus a flush input for pipeline squash.

Parameters:
XLEN, 64, operand/result width; must be 32 or 64.
BPC, 8, multiplier bits retired per cycle; one of 1, 2, 4, 8, 16; must divide XLEN.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  request; accepted only when busy=0.
op  in  3  mul_op_e: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 decode as MUL.
op1  in  XLEN  multiplicand (rs1).
op2  in  XLEN  multiplier (rs2).
flush  in  1  abort current operation.
busy  out  1  operation in flight.
valid  out  1  one-cycle pulse; result is valid.
result  out  XLEN  result; held until the next accepted start.

Behaviour:
- Reset: busy=0, valid=0, result=0, FSM=IDLE, all datapath registers 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, start=1:
  - Latch op.
  - Form operand magnitudes: signed for MULH/MULW (both), op1 only for MULHSU.
  - MULW uses sign-extended low 32 bits of both operands.
  - Set neg = sign1 XOR sign2; clear the 2*XLEN accumulator.
  - Iteration counter = XLEN/BPC; go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - acc += mcand * mplier[BPC-1:0], with 2*XLEN-bit add.
  - mcand <<= BPC; mplier >>= BPC; counter decrements.
  - Leave for FIX when counter reaches 0.
- FIX (one cycle):
  - If neg, acc = two's complement of acc (full 2*XLEN).
  - Select the result:
    - MUL: acc[XLEN-1:0].
    - MULH/MULHSU/MULHU: acc[2*XLEN-1:XLEN].
    - MULW: sign-extend acc[31:0] to XLEN.
  - Register the result; go to DONE.
- DONE: valid=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: start edge to valid = XLEN/BPC + 2 cycles. Default XLEN=64, BPC=8 gives 10 cycles. Throughput: a new start is accepted in the DONE cycle, since busy=0 there.
- start while busy=1 is ignored. Operands are not re-sampled.
- flush=1 in any state:
  - Next state is IDLE; busy=0 and no valid pulse.
  - result keeps its previous value.
  - flush has priority over start in the same cycle.
- In DONE, flush suppresses nothing: valid has already been registered.
- Asynchronous rst mid-operation: everything returns to reset values immediately. No valid pulse follows.
- Accumulator adds use the shared carry-select adder. No overflow detection; the product is exact in 2*XLEN bits.

Optional Feature:
INT_MUL_EARLY_OUT_EN
- Defined: RUN exits to FIX when the remaining mplier is 0 after the current step, or when the counter reaches 0.
  - Latency = ceil(significant multiplier-magnitude bits / BPC) + 2, minimum 3.
  - MULW needs at most 32/BPC RUN cycles.
- Not defined: RUN always takes exactly XLEN/BPC cycles. Latency is fixed.
- Results are identical in both builds.

Decomposition:
- Shared package mul_pkg holds:
  - mul_op_e enum (3 bits) with the op encodings above;
  - mul_state_e (IDLE, RUN, FIX, DONE);
  - localparam ITER = XLEN/BPC.
- One natural sub-module: mul_pp_step, combinational. It computes acc + mcand*digit for one BPC-bit digit using the existing cseladd.
- Two-argument compile-time parameter check: XLEN % BPC == 0.

Test Plan:
- MUL, op1=3, op2=5 → result=15. valid at cycle 10 (early-out off) or cycle 3 (early-out on); busy high until valid.
- MULH 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → 0x4000_0000_0000_0000. MULH −1×−1 → 0.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE. MULHSU op1=−1, op2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF.
- MULW op1=0x7FFF_FFFF, op2=2 → 0xFFFF_FFFF_FFFF_FFFE. MULW with op1 upper bits = 0xDEAD_BEEF gives an unchanged result.
- Second start at cycle 4 of an operation is ignored: the first result is correct and exactly one valid pulse occurs. Back-to-back start in the DONE cycle is accepted, giving two valid pulses 10 cycles apart.
- flush at cycle 5 → busy=0 next cycle, no valid, result unchanged. rst pulsed mid-RUN → all outputs 0 immediately, no valid afterwards.
